// File: rtl/pong_pkg.sv
// Shared definitions for the pong datapath: FSM states, game_state codes,
// the score width and a saturating score increment.
package pong_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    PLAY  = 2'd2,
    OVER  = 2'd3
  } state_t;

  localparam logic [1:0] GS_RESET = 2'b00;
  localparam logic [1:0] GS_PLAY  = 2'b01;
  localparam logic [1:0] GS_P1WIN = 2'b10;
  localparam logic [1:0] GS_P2WIN = 2'b11;

  localparam int SCORE_W = 4;

  // Add one to a score but never exceed the given ceiling.
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] value,
                                                 input logic [SCORE_W-1:0] ceiling);
    return (value >= ceiling) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/serve_timer.sv
// Millisecond counter for the serve hold. Counts enabled ticks and raises
// o_done combinationally on the tick that completes SERVE_MS ticks, wrapping
// back to zero on that same edge.
module serve_timer
  import pong_pkg::*;
#(
  parameter int SERVE_MS = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_tick,
  output logic o_done
);

  // Guard against a zero-width counter when SERVE_MS is 1.
  localparam int CNT_W = (SERVE_MS > 1) ? $clog2(SERVE_MS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SERVE_MS - 1);

  logic [CNT_W-1:0] r_count;

  assign o_done = i_tick & (r_count == LAST);

  // Count ticks while enabled; clear has priority so any entry starts from zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_tick) begin
      r_count <= o_done ? '0 : r_count + 1'b1;
    end
  end

endmodule

// File: rtl/score_keeper.sv
// Converts goal levels into saturating player scores and sequences the rally:
// waits for start, holds the ball for a serve delay after every goal, and
// freezes once game_state reports a winner.
module score_keeper
  import pong_pkg::*;
#(
  parameter int SERVE_MS  = 1000,
  parameter int MAX_SCORE = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick_1ms,
  input  logic               start,
  input  logic               goal_p1,
  input  logic               goal_p2,
  input  logic [1:0]         game_state,
  output logic [SCORE_W-1:0] p1_score,
  output logic [SCORE_W-1:0] p2_score,
  output logic               serve_hold,
  output logic               serve_dir
);

  localparam logic [SCORE_W-1:0] MAX_S = SCORE_W'(MAX_SCORE);

  state_t             r_state;
  logic [SCORE_W-1:0] r_p1;
  logic [SCORE_W-1:0] r_p2;
  logic               r_hold;
  logic               r_dir;
  logic               r_start_prev;
  logic               r_goal1_prev;
  logic               r_goal2_prev;

  logic               w_rise_start;
  logic               w_rise_p1;
  logic               w_rise_p2;
  logic               w_win;
  logic               w_timer_clear;
  logic               w_timer_tick;
  logic               w_timer_done;

  assign w_rise_start = start & ~r_start_prev;
  assign w_rise_p1    = goal_p1 & ~r_goal1_prev;
  assign w_rise_p2    = goal_p2 & ~r_goal2_prev;
  assign w_win        = (game_state == GS_P1WIN) || (game_state == GS_P2WIN);

  // The timer only runs in SERVE; holding it clear elsewhere means every
  // entry into SERVE starts a fresh delay.
  assign w_timer_clear = (r_state != SERVE);
  assign w_timer_tick  = tick_1ms & (r_state == SERVE);

  serve_timer #(
    .SERVE_MS(SERVE_MS)
  ) u_serve_timer (
    .clk     (clk),
    .reset   (reset),
    .i_clear (w_timer_clear),
    .i_tick  (w_timer_tick),
    .o_done  (w_timer_done)
  );

  // Previous-cycle copies of the level inputs; start_prev resets high so a
  // button held through reset release does not start a match.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_start_prev <= 1'b1;
      r_goal1_prev <= 1'b0;
      r_goal2_prev <= 1'b0;
    end else begin
      r_start_prev <= start;
      r_goal1_prev <= goal_p1;
      r_goal2_prev <= goal_p2;
    end
  end

  // Rally FSM with scores and registered outputs; serve_hold follows the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_p1    <= '0;
      r_p2    <= '0;
      r_hold  <= 1'b1;
      r_dir   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_rise_start) begin
            r_state <= SERVE;
            r_p1    <= '0;
            r_p2    <= '0;
            r_hold  <= 1'b1;
          end
        end
        SERVE: begin
          if (w_win) begin
            r_state <= OVER;
            r_hold  <= 1'b1;
          end else if (w_timer_done) begin
            r_state <= PLAY;
            r_hold  <= 1'b0;
          end
        end
        PLAY: begin
          if (w_win) begin
            r_state <= OVER;
            r_hold  <= 1'b1;
          end else if (w_rise_p1 && w_rise_p2) begin
            r_state <= SERVE;
            r_hold  <= 1'b1;
          end else if (w_rise_p1) begin
            r_p1    <= sat_inc(r_p1, MAX_S);
            r_dir   <= 1'b1;
            r_state <= SERVE;
            r_hold  <= 1'b1;
          end else if (w_rise_p2) begin
            r_p2    <= sat_inc(r_p2, MAX_S);
            r_dir   <= 1'b0;
            r_state <= SERVE;
            r_hold  <= 1'b1;
          end
        end
        OVER: begin
          if (w_rise_start) begin
            r_state <= SERVE;
            r_p1    <= '0;
            r_p2    <= '0;
            r_hold  <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_hold  <= 1'b1;
        end
      endcase
    end
  end

  assign p1_score   = r_p1;
  assign p2_score   = r_p2;
  assign serve_hold = r_hold;
  assign serve_dir  = r_dir;

endmodule

// File: tb/tb_score_keeper.sv
// Scoreboard bench for score_keeper: a driver applies one input vector per
// cycle and queues the outputs a behavioural match model predicts; a monitor
// pops and compares just after every rising edge.
module tb_score_keeper;
  import pong_pkg::*;

  localparam int SERVE_MS  = 4;
  localparam int MAX_SCORE = 15;
  localparam int WIN       = 5;

  typedef struct packed {
    logic [3:0] p1;
    logic [3:0] p2;
    logic       hold;
    logic       dir;
  } outs_t;

  localparam outs_t RESET_OUTS = '{p1: 4'd0, p2: 4'd0, hold: 1'b1, dir: 1'b0};

  logic       clk;
  logic       reset;
  logic       tick_1ms;
  logic       start;
  logic       goal_p1;
  logic       goal_p2;
  logic [1:0] game_state;
  logic [3:0] p1_score;
  logic [3:0] p2_score;
  logic       serve_hold;
  logic       serve_dir;

  score_keeper #(
    .SERVE_MS (SERVE_MS),
    .MAX_SCORE(MAX_SCORE)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .tick_1ms  (tick_1ms),
    .start     (start),
    .goal_p1   (goal_p1),
    .goal_p2   (goal_p2),
    .game_state(game_state),
    .p1_score  (p1_score),
    .p2_score  (p2_score),
    .serve_hold(serve_hold),
    .serve_dir (serve_dir)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Match model: phase 0 waiting, 1 serving, 2 rallying, 3 finished.
  int    mPhase;
  int    ticksLeft;
  int    mP1;
  int    mP2;
  bit    mDir;
  bit    mPrevStart;
  bit    mPrevG1;
  bit    mPrevG2;
  bit    gsAuto;

  outs_t expQ[$];
  int    vectorCount;
  int    missCount;

  function automatic void modelReset();
    mPhase     = 0;
    ticksLeft  = 0;
    mP1        = 0;
    mP2        = 0;
    mDir       = 1'b0;
    mPrevStart = 1'b1;
    mPrevG1    = 1'b0;
    mPrevG2    = 1'b0;
  endfunction

  function automatic void beginServe(bit clearScores);
    mPhase    = 1;
    ticksLeft = SERVE_MS;
    if (clearScores) begin
      mP1 = 0;
      mP2 = 0;
    end
  endfunction

  // Feedback the downstream game_state block would present: a winner code
  // one cycle after a score reaches WIN, otherwise playing.
  function automatic logic [1:0] gsFor();
    if (!gsAuto)     return 2'b01;
    if (mPhase == 0) return 2'b00;
    if (mP1 >= WIN)  return 2'b10;
    if (mP2 >= WIN)  return 2'b11;
    return 2'b01;
  endfunction

  function automatic void modelStep(bit s, bit g1, bit g2, bit t, logic [1:0] gs);
    bit riseS;
    bit rise1;
    bit rise2;
    bit won;
    riseS      = s && !mPrevStart;
    rise1      = g1 && !mPrevG1;
    rise2      = g2 && !mPrevG2;
    won        = gs[1];
    mPrevStart = s;
    mPrevG1    = g1;
    mPrevG2    = g2;
    case (mPhase)
      0: if (riseS) beginServe(1'b1);
      1: begin
        if (won) mPhase = 3;
        else if (t) begin
          ticksLeft = ticksLeft - 1;
          if (ticksLeft == 0) mPhase = 2;
        end
      end
      2: begin
        if (won) mPhase = 3;
        else if (rise1 && rise2) beginServe(1'b0);
        else if (rise1) begin
          if (mP1 < MAX_SCORE) mP1 = mP1 + 1;
          mDir = 1'b1;
          beginServe(1'b0);
        end else if (rise2) begin
          if (mP2 < MAX_SCORE) mP2 = mP2 + 1;
          mDir = 1'b0;
          beginServe(1'b0);
        end
      end
      default: if (riseS) beginServe(1'b1);
    endcase
  endfunction

  function automatic outs_t modelOuts();
    outs_t o;
    o.p1   = 4'(mP1);
    o.p2   = 4'(mP2);
    o.hold = (mPhase != 2);
    o.dir  = mDir;
    return o;
  endfunction

  task automatic checkOutput(input string name, input outs_t exp);
    outs_t act;
    act = '{p1: p1_score, p2: p2_score, hold: serve_hold, dir: serve_dir};
    vectorCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s #%0d: got p1=%0d p2=%0d hold=%b dir=%b, expected p1=%0d p2=%0d hold=%b dir=%b",
               name, vectorCount, act.p1, act.p2, act.hold, act.dir,
               exp.p1, exp.p2, exp.hold, exp.dir);
    end
  endtask

  // One cycle of stimulus: drive on the falling edge and queue the prediction.
  task automatic applyStimulus(input bit rstN, input bit s, input bit g1, input bit g2, input bit t);
    @(negedge clk);
    reset      = rstN;
    start      = s;
    goal_p1    = g1;
    goal_p2    = g2;
    tick_1ms   = t;
    game_state = gsFor();
    if (!rstN) modelReset();
    else       modelStep(s, g1, g2, t, game_state);
    expQ.push_back(modelOuts());
  endtask

  // Run idle cycles with random ticks until the modelled serve ends (bounded).
  task automatic serveOut();
    for (int i = 0; i < 200 && mPhase == 1; i++)
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
  endtask

  task automatic pulseGoal(input bit g1, input bit g2);
    applyStimulus(1'b1, 1'b0, g1, g2, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Pull reset low between edges and check the outputs before any clock edge.
  task automatic asyncResetCheck();
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    checkOutput("async_reset", RESET_OUTS);
    modelReset();
  endtask

  // Monitor: compare the queued prediction just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (expQ.size() > 0) checkOutput("outputs", expQ.pop_front());
  end

  // Guard against the run never finishing.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit s;
    bit g1;
    bit g2;
    reset       = 1'b0;
    start       = 1'b1;
    goal_p1     = 1'b0;
    goal_p2     = 1'b0;
    tick_1ms    = 1'b0;
    game_state  = 2'b00;
    gsAuto      = 1'b1;
    vectorCount = 0;
    missCount   = 0;
    modelReset();

    $display("[TB] reset with start held, then release and press");
    repeat (3) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (6) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
    repeat (2) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    serveOut();

    $display("[TB] held p1 goal counts once, goals ignored while serving");
    repeat (10) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    pulseGoal(1'b0, 1'b1);
    pulseGoal(1'b1, 1'b0);
    serveOut();

    $display("[TB] simultaneous goals re-serve");
    pulseGoal(1'b1, 1'b1);
    serveOut();

    $display("[TB] p2 wins at five, game frozen, restart");
    for (int i = 0; i < WIN; i++) begin
      pulseGoal(1'b0, 1'b1);
      serveOut();
    end
    for (int i = 0; i < 10; i++)
      applyStimulus(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("[TB] p1 score saturation");
    gsAuto = 1'b0;
    serveOut();
    for (int i = 0; i < 20; i++) begin
      pulseGoal(1'b1, 1'b0);
      serveOut();
    end

    $display("[TB] asynchronous reset mid-serve");
    pulseGoal(1'b1, 1'b0);
    asyncResetCheck();
    repeat (2) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    repeat (3) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("[TB] randomized matches");
    gsAuto = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    g1 = 1'b0;
    g2 = 1'b0;
    for (int i = 0; i < 600; i++) begin
      s = ($urandom_range(0, 30) == 0);
      if ($urandom_range(0, 5) == 0) g1 = ~g1;
      if ($urandom_range(0, 5) == 0) g2 = ~g2;
      applyStimulus(1'b1, s, g1, g2, 1'($urandom_range(0, 2) == 0));
    end

    @(posedge clk);
    #2;
    vectorCount++;
    if (expQ.size() != 0) begin
      missCount++;
      $display("[TB] FAIL drain: got %0d pending predictions, expected 0", expQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
